sign_narrower: RTL and testbench



---
 rtl/sign_narrower_pkg.sv | 25 ++
 rtl/sign_narrower_fifo.sv | 66 ++++++
 rtl/sign_narrower.sv | 94 +++++++++
 tb/tb_sign_narrower.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_narrower_pkg.sv
// Shared constants and the fit test for narrowing two's-complement words.
// The fit test is also used by the ALU immediate checker.
package sign_narrower_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 8;

    localparam logic [OUT_W_DEF-1:0] SAT_POS = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    localparam logic [OUT_W_DEF-1:0] SAT_NEG = {1'b1, {(OUT_W_DEF-1){1'b0}}};

    localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

    // A word fits when every bit from out_w-1 up to in_w-1 equals the new sign bit.
    function automatic logic fits_narrow(input logic [31:0] word, input int in_w, input int out_w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= out_w && i < in_w && word[i] != word[out_w-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/sign_narrower_fifo.sv
// Small synchronous FIFO holding narrowed results as {ovf, value}.
// The head is read straight from storage, so it is stable until popped.
module narrow_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? bump(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sign_narrower.sv
// Streaming 16->8 narrowing unit: fit test, optional saturation, buffered output
// and overflow statistics.
module sign_narrower
    import sign_narrower_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [7:0]       ovf_count,
    input  logic             clr
);

    logic             fit;
    logic [OUT_W-1:0] result;
    logic             accept;
    logic             ovf_accept;
    logic             fifo_full, fifo_empty;
    logic [OUT_W:0]   head;

    logic             ovf_sticky_q, ovf_sticky_d;
    logic [7:0]       ovf_count_q, ovf_count_d;

    assign fit = fits_narrow(32'(in), IN_W, OUT_W);

    always_comb begin
        result = in[OUT_W-1:0];
        if (!fit && sat_en) begin
            result = in[IN_W-1] ? OUT_W'(SAT_NEG) : OUT_W'(SAT_POS);
        end
    end

    assign in_ready   = !fifo_full;
    assign out_valid  = !fifo_empty;
    assign accept     = in_valid && in_ready;
    assign ovf_accept = accept && !fit;

    narrow_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .data_i  ({!fit, result}),
        .pop_i   (out_ready),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out = head[OUT_W-1:0];
    assign ovf = head[OUT_W];

    // Clear wins over history, but an overflow accepted in the same cycle still counts.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (clr) begin
            ovf_sticky_d = ovf_accept;
            ovf_count_d  = ovf_accept ? 8'd1 : 8'd0;
        end else if (ovf_accept) begin
            ovf_sticky_d = 1'b1;
            if (ovf_count_q != OVF_CNT_MAX) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= 8'd0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_sign_narrower.sv
// Self-checking bench for sign_narrower: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_sign_narrower;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] inWord = '0;
    logic        sat_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  outWord;
    logic        ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        clr = 1'b0;

    int nVec = 0;
    int nMis = 0;

    typedef struct {
        logic [15:0] word;
        logic        sat;
        logic [7:0]  expOut;
        logic        expOvf;
    } vec_t;

    vec_t vecs[6];

    logic [8:0]  modelQ[$];
    int          mCnt;
    logic        mSticky;
    logic [15:0] bnd[8];

    sign_narrower u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (inWord),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (outWord),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    // Narrowing defined by value range: anything outside -128..127 overflows.
    function automatic logic [8:0] refNarrow(input logic [15:0] word, input logic sat);
        int v;
        v = int'($signed(word));
        if (v >= -128 && v <= 127) return {1'b0, word[7:0]};
        if (!sat) return {1'b1, word[7:0]};
        return (v > 0) ? {1'b1, 8'd127} : {1'b1, 8'h80};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] w, input logic s,
                                 input logic ordy, input logic c);
        @(negedge clk);
        in_valid  = v;
        inWord    = w;
        sat_en    = s;
        out_ready = ordy;
        clr       = c;
    endtask

    task automatic stepAndSettle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 1'b1, 8'hFF, 1'b0};
        vecs[1] = '{16'h007F, 1'b1, 8'h7F, 1'b0};
        vecs[2] = '{16'hFF80, 1'b1, 8'h80, 1'b0};
        vecs[3] = '{16'h0080, 1'b1, 8'h7F, 1'b1};
        vecs[4] = '{16'h0080, 1'b0, 8'h80, 1'b1};
        vecs[5] = '{16'h8000, 1'b1, 8'h80, 1'b1};
        bnd = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F,
                16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};

        #1;
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset in_ready", 32'(in_ready), 1);
        checkOutput("reset out", 32'(outWord), 0);
        checkOutput("reset ovf", 32'(ovf), 0);
        checkOutput("reset ovf_sticky", 32'(ovf_sticky), 0);
        checkOutput("reset ovf_count", 32'(ovf_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].word, vecs[i].sat, 1'b1, 1'b0);
            stepAndSettle();
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
            checkOutput($sformatf("vec%0d out", i), 32'(outWord), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].expOvf));
            stepAndSettle();
        end
        checkOutput("table ovf_count", 32'(ovf_count), 3);
        checkOutput("table ovf_sticky", 32'(ovf_sticky), 1);

        // Backpressure: two accepts fill the buffer, third waits.
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        stepAndSettle();
        checkOutput("bp in_ready after 1", 32'(in_ready), 1);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        stepAndSettle();
        checkOutput("bp in_ready after 2", 32'(in_ready), 0);
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        stepAndSettle();
        checkOutput("bp in_ready held", 32'(in_ready), 0);
        checkOutput("bp head stable", 32'(outWord), 32'h01);
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
        checkOutput("bp head 1", 32'(outWord), 32'h01);
        stepAndSettle();
        checkOutput("bp head 2", 32'(outWord), 32'h02);
        checkOutput("bp in_ready reopen", 32'(in_ready), 1);
        stepAndSettle();
        checkOutput("bp head 3", 32'(outWord), 32'h03);
        checkOutput("bp valid 3", 32'(out_valid), 1);
        in_valid = 1'b0;
        stepAndSettle();
        checkOutput("bp drained", 32'(out_valid), 0);

        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        stepAndSettle();
        clr = 1'b0;
        checkOutput("clr alone count", 32'(ovf_count), 0);
        checkOutput("clr alone sticky", 32'(ovf_sticky), 0);

        // Continuous streaming: one word in and one out every cycle.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
            stepAndSettle();
            checkOutput($sformatf("stream%0d head", i), {23'd0, ovf, outWord},
                        32'(refNarrow(16'(i), 1'b0)));
            checkOutput($sformatf("stream%0d in_ready", i), 32'(in_ready), 1);
            checkOutput($sformatf("stream%0d out_valid", i), 32'(out_valid), 1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        stepAndSettle();
        checkOutput("stream drained", 32'(out_valid), 0);
        checkOutput("stream ovf_count", 32'(ovf_count), 128);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 16'h1000, 1'b1, 1'b1, 1'b0);
            @(posedge clk);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        stepAndSettle();
        checkOutput("stats saturated count", 32'(ovf_count), 255);
        checkOutput("stats sticky", 32'(ovf_sticky), 1);
        applyStimulus(1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
        stepAndSettle();
        checkOutput("clr+ovf count", 32'(ovf_count), 1);
        checkOutput("clr+ovf sticky", 32'(ovf_sticky), 1);
        checkOutput("clr+ovf head", {23'd0, ovf, outWord}, 32'h180);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        stepAndSettle();
        clr = 1'b0;
        checkOutput("clr after count", 32'(ovf_count), 0);
        checkOutput("clr after sticky", 32'(ovf_sticky), 0);

        // Mid-stream asynchronous reset with a full buffer.
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        stepAndSettle();
        applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        stepAndSettle();
        checkOutput("pre-reset full", 32'(in_ready), 0);
        checkOutput("pre-reset sticky", 32'(ovf_sticky), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 0);
        checkOutput("async reset in_ready", 32'(in_ready), 1);
        checkOutput("async reset sticky", 32'(ovf_sticky), 0);
        checkOutput("async reset count", 32'(ovf_count), 0);
        checkOutput("async reset head", {23'd0, ovf, outWord}, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepAndSettle();
            checkOutput("no stale word", 32'(out_valid), 0);
        end

        // Randomized traffic against the queue model.
        modelQ.delete();
        mCnt = 0;
        mSticky = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [15:0] w;
            logic        doPush, doPop, accOvf;
            logic [8:0]  res;
            case ($urandom_range(0, 2))
                0: w = 16'($signed(8'($urandom_range(0, 255))));
                1: w = 16'($urandom);
                default: w = bnd[$urandom_range(0, 7)];
            endcase
            applyStimulus($urandom_range(0, 3) != 0, w, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
            #1;
            checkOutput("rand out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
            checkOutput("rand in_ready", 32'(in_ready), 32'(modelQ.size() < 2));
            if (modelQ.size() != 0) begin
                checkOutput("rand head", {23'd0, ovf, outWord}, 32'(modelQ[0]));
            end
            checkOutput("rand ovf_count", 32'(ovf_count), 32'(mCnt));
            checkOutput("rand ovf_sticky", 32'(ovf_sticky), 32'(mSticky));
            res    = refNarrow(inWord, sat_en);
            doPush = in_valid && (modelQ.size() < 2);
            doPop  = out_ready && (modelQ.size() != 0);
            accOvf = doPush && res[8];
            @(posedge clk);
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(res);
            if (clr) begin
                mCnt    = accOvf ? 1 : 0;
                mSticky = accOvf;
            end else if (accOvf) begin
                mSticky = 1'b1;
                if (mCnt < 255) mCnt++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
